// File: rtl/regfile_write_scheduler_if.sv
// Writeback requester bus for regfile_write_scheduler.
// One valid/addr/data slice per requester; the scheduler returns a one-hot (or zero) ready.
interface regfile_write_scheduler_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;

    // Requester side drives the request, scheduler side drives the grant.
    modport master (output req_valid, req_addr, req_data, input  req_ready);
    modport slave  (input  req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/regfile_write_scheduler.sv
// Register-file write port scheduler.
// Arbitrates NUM_REQ writeback requesters onto the single register-file write port
// (round-robin by default), keeps a per-register outstanding-write scoreboard fed by
// decode reservations, and reports source-operand hazards to decode.
// Build option: define REGFILE_WRITE_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins
// priority (no round-robin pointer; starvation allowed).
module regfile_write_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    regfile_write_scheduler_if.slave  req,
    input  logic                      reserve_valid,
    input  logic [ADDR_W-1:0]         reserve_addr,
    output logic                      reserve_ready,
    input  logic [ADDR_W-1:0]         check_addr_1,
    input  logic [ADDR_W-1:0]         check_addr_2,
    output logic                      busy_1,
    output logic                      busy_2,
    output logic                      stall,
    output logic [ADDR_W-1:0]         rf_write_address,
    output logic [DATA_W-1:0]         rf_write_data,
    output logic                      rf_write_enable
);
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int IDX_W    = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               found;
    logic               transfer;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic                do_reserve;

`ifndef REGFILE_WRITE_SCHED_FIXED_PRIO_EN
    logic [IDX_W-1:0] rr_ptr;
`endif

    // Pick the winning requester: first valid index at or after the pointer (or lowest index).
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
`ifdef REGFILE_WRITE_SCHED_FIXED_PRIO_EN
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req.req_valid[IDX_W'(k)]) begin
                grant_idx = IDX_W'(k);
                found     = 1'b1;
            end
        end
`else
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [IDX_W-1:0] idx;
            idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req.req_valid[idx]) begin
                grant_idx = idx;
                found     = 1'b1;
            end
        end
`endif
        if (found && !reset) begin
            grant[grant_idx] = 1'b1;
        end
    end

    assign req.req_ready = grant;
    assign transfer      = |grant;
    assign win_addr      = req.req_addr[grant_idx * ADDR_W +: ADDR_W];
    assign win_data      = req.req_data[grant_idx * DATA_W +: DATA_W];

    // Register the winner onto the write port; writes to r0 are accepted but never enabled.
    always_ff @(posedge clock) begin
        // NOTE: state is assigned with <= so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            rf_write_enable  <= 1'b0;
            rf_write_address <= '0;
            rf_write_data    <= '0;
        end else if (transfer) begin
            rf_write_enable  <= (win_addr != '0);
            rf_write_address <= win_addr;
            rf_write_data    <= win_data;
        end else begin
            rf_write_enable  <= 1'b0;
        end
    end

`ifndef REGFILE_WRITE_SCHED_FIXED_PRIO_EN
    // Advance the round-robin pointer past the requester that just transferred.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    assign reserve_ready = !reset && ((reserve_addr == '0) || (cnt[reserve_addr] != CNT_MAX));
    assign do_reserve    = reserve_valid && reserve_ready && (reserve_addr != '0);

    // Per-register increment (reservation) and decrement (write retiring this edge) requests.
    always_comb begin
        inc = '0;
        dec = '0;
        if (do_reserve) begin
            inc[reserve_addr] = 1'b1;
        end
        if (rf_write_enable) begin
            dec[rf_write_address] = 1'b1;
        end
    end

    // Scoreboard counters; r0 stays zero, collisions cancel, a retire at zero saturates.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: this array is control state, not data storage, so it is cleared on reset.
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (inc[r] && !dec[r]) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (dec[r] && !inc[r] && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    assign busy_1 = (check_addr_1 != '0) && (cnt[check_addr_1] != '0);
    assign busy_2 = (check_addr_2 != '0) && (cnt[check_addr_2] != '0);
    assign stall  = busy_1 || busy_2;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench for regfile_write_scheduler: directed steps followed by a random
// phase, all compared against a behavioural model of grants, write port and scoreboard.
module tb_regfile_write_scheduler;
    localparam int NUM_REQ  = 3;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 2;
    localparam int NUM_REGS = 32;
    localparam int CNT_MAX  = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              reserve_valid;
    logic [ADDR_W-1:0] reserve_addr;
    logic              reserve_ready;
    logic [ADDR_W-1:0] check_addr_1;
    logic [ADDR_W-1:0] check_addr_2;
    logic              busy_1;
    logic              busy_2;
    logic              stall;
    logic [ADDR_W-1:0] rf_write_address;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_write_enable;

    regfile_write_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_write_scheduler #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .req              (bus),
        .reserve_valid    (reserve_valid),
        .reserve_addr     (reserve_addr),
        .reserve_ready    (reserve_ready),
        .check_addr_1     (check_addr_1),
        .check_addr_2     (check_addr_2),
        .busy_1           (busy_1),
        .busy_2           (busy_2),
        .stall            (stall),
        .rf_write_address (rf_write_address),
        .rf_write_data    (rf_write_data),
        .rf_write_enable  (rf_write_enable)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;

    // Requester state as the bench sees it.
    logic [NUM_REQ-1:0] valid_v;
    int                 addr_v [NUM_REQ];
    logic [DATA_W-1:0]  data_v [NUM_REQ];

    // Reference model: pending-write counts, rotation start point, write port contents.
    int                m_cnt [NUM_REGS];
    int                m_ptr;
    bit                m_we;
    int                m_wa;
    logic [DATA_W-1:0] m_wd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i]                   = valid_v[i];
            bus.req_addr[i*ADDR_W +: ADDR_W]   = ADDR_W'(addr_v[i]);
            bus.req_data[i*DATA_W +: DATA_W]   = data_v[i];
        end
    endtask

    task automatic set_req(input int i, input bit v, input int a, input logic [DATA_W-1:0] d);
        valid_v[i] = v;
        addr_v[i]  = a;
        data_v[i]  = d;
        apply();
    endtask

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = 0;
        m_ptr = 0;
        m_we  = 1'b0;
        m_wa  = 0;
        m_wd  = '0;
    endtask

    // Winner per the rules: first valid requester scanning from the rotation start.
    function automatic int model_grant();
        if (reset) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (m_ptr + k) % NUM_REQ;
            if (valid_v[i]) return i;
        end
        return -1;
    endfunction

    // One clock: check combinational outputs before the edge, advance model, check registered outputs.
    task automatic cycle(input string tag, output int granted);
        logic [NUM_REQ-1:0] exp_rdy;
        bit                 exp_rr, exp_b1, exp_b2, do_res;
        int                 g;
        #1;
        g       = model_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_rr = !reset && (reserve_addr == 0 || m_cnt[reserve_addr] != CNT_MAX);
        exp_b1 = (check_addr_1 != 0) && (m_cnt[check_addr_1] != 0);
        exp_b2 = (check_addr_2 != 0) && (m_cnt[check_addr_2] != 0);
        check({tag, " req_ready"},     bus.req_ready, exp_rdy);
        check({tag, " reserve_ready"}, reserve_ready, exp_rr);
        check({tag, " busy_1"},        busy_1, exp_b1);
        check({tag, " busy_2"},        busy_2, exp_b2);
        check({tag, " stall"},         stall, exp_b1 || exp_b2);
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            do_res = reserve_valid && exp_rr && (reserve_addr != 0);
            if (m_we && !(do_res && reserve_addr == m_wa) && m_cnt[m_wa] > 0) m_cnt[m_wa]--;
            if (do_res && !(m_we && m_wa == reserve_addr)) m_cnt[reserve_addr]++;
            if (g >= 0) begin
                m_we = (addr_v[g] != 0);
                m_wa = addr_v[g];
                m_wd = data_v[g];
`ifdef REGFILE_WRITE_SCHED_FIXED_PRIO_EN
                m_ptr = 0;
`else
                m_ptr = (g + 1) % NUM_REQ;
`endif
            end else begin
                m_we = 1'b0;
            end
        end
        #1;
        check({tag, " rf_write_enable"},  rf_write_enable, m_we);
        check({tag, " rf_write_address"}, rf_write_address, m_wa);
        check({tag, " rf_write_data"},    rf_write_data, m_wd);
        granted = g;
    endtask

    initial begin
        int g;
        int last_g;
        valid_v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_v[i] = 0;
            data_v[i] = '0;
        end
        apply();
        reset         = 1'b1;
        reserve_valid = 1'b0;
        reserve_addr  = '0;
        check_addr_1  = '0;
        check_addr_2  = '0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check("reset rf_write_enable",  rf_write_enable, 1'b0);
        check("reset rf_write_address", rf_write_address, '0);
        check("reset rf_write_data",    rf_write_data, '0);
        check("reset req_ready",        bus.req_ready, '0);
        check("reset reserve_ready",    reserve_ready, 1'b0);
        check("reset busy_1",           busy_1, 1'b0);
        reset = 1'b0;

        // All three requesters held valid: grants rotate 0,1,2,0.
        set_req(0, 1'b1, 5, 32'hAAAA_0000);
        set_req(1, 1'b1, 6, 32'hBBBB_1111);
        set_req(2, 1'b1, 7, 32'hCCCC_2222);
        for (int n = 0; n < 4; n++) begin
            cycle("rr", g);
            check("rr grant order", g, n % NUM_REQ);
            check("rr write address", rf_write_address, 5 + (n % NUM_REQ));
            check("rr write enable", rf_write_enable, 1'b1);
        end
        valid_v = '0;
        apply();
        cycle("idle", g);

        // Requester 1 writes r0: accepted, discarded, pointer moves to 2.
        set_req(1, 1'b1, 0, 32'hDEAD_BEEF);
        cycle("r0 write", g);
        check("r0 grant", g, 1);
        check("r0 enable", rf_write_enable, 1'b0);
        valid_v = '0;
        set_req(0, 1'b1, 1, 32'h0000_0001);
        set_req(2, 1'b1, 2, 32'h0000_0002);
        cycle("after r0", g);
        check("after r0 grant", g, 2);
        valid_v = '0;
        apply();
        cycle("idle", g);

        // Two reservations of r9, then two writes retire them.
        reserve_valid = 1'b1;
        reserve_addr  = 5'd9;
        check_addr_1  = 5'd9;
        cycle("res9a", g);
        cycle("res9b", g);
        reserve_valid = 1'b0;
        #1;
        check("r9 busy_1 at cnt2", busy_1, 1'b1);
        check("r9 stall at cnt2", stall, 1'b1);
        set_req(0, 1'b1, 9, 32'h9999_0001);
        cycle("wr9a", g);
        set_req(0, 1'b1, 9, 32'h9999_0002);
        cycle("wr9b", g);
        valid_v = '0;
        apply();
        #1;
        check("r9 busy_1 after first retire", busy_1, 1'b1);
        cycle("wr9 drain", g);
        #1;
        check("r9 busy_1 after second retire", busy_1, 1'b0);

        // Fill r4 to the limit; a further reservation is refused.
        reserve_valid = 1'b1;
        reserve_addr  = 5'd4;
        check_addr_2  = 5'd4;
        for (int n = 0; n < CNT_MAX; n++) cycle("res4", g);
        #1;
        check("r4 full reserve_ready", reserve_ready, 1'b0);
        cycle("res4 refused", g);
        check("r4 still busy", busy_2, 1'b1);
        reserve_addr = 5'd0;
        check_addr_1 = 5'd0;
        #1;
        check("r0 reserve_ready", reserve_ready, 1'b1);
        check("r0 busy_1", busy_1, 1'b0);
        cycle("res0", g);
        reserve_valid = 1'b0;

        // Reserve r12 while a write to r12 retires: count holds at 1.
        reserve_valid = 1'b1;
        reserve_addr  = 5'd12;
        check_addr_2  = 5'd12;
        cycle("res12", g);
        reserve_valid = 1'b0;
        set_req(1, 1'b1, 12, 32'h1212_1212);
        cycle("wr12", g);
        valid_v = '0;
        apply();
        reserve_valid = 1'b1;
        cycle("res12 collide", g);
        reserve_valid = 1'b0;
        #1;
        check("r12 busy after collision", busy_2, 1'b1);
        cycle("r12 idle", g);
        check("r12 busy after idle", busy_2, 1'b1);

        // Reset right after a write to r3 was granted.
        check_addr_1 = 5'd4;
        set_req(2, 1'b1, 3, 32'h3333_3333);
        cycle("wr3", g);
        reset = 1'b1;
        valid_v = '0;
        set_req(1, 1'b1, 6, 32'h6666_6666);
        set_req(2, 1'b1, 7, 32'h7777_7777);
        cycle("mid reset", g);
        check("mid reset enable", rf_write_enable, 1'b0);
        check("mid reset busy_1", busy_1, 1'b0);
        check("mid reset busy_2", busy_2, 1'b0);
        reset = 1'b0;
        cycle("post reset", g);
        check("post reset grant", g, 1);

        // Random phase: requesters hold requests until granted.
        last_g = g;
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!valid_v[i] || i == last_g) begin
                    valid_v[i] = $urandom_range(0, 1);
                    addr_v[i]  = $urandom_range(0, 7);
                    data_v[i]  = $urandom;
                end
            end
            apply();
            reserve_valid = $urandom_range(0, 1);
            reserve_addr  = ADDR_W'($urandom_range(0, 7));
            check_addr_1  = ADDR_W'($urandom_range(0, 7));
            check_addr_2  = ADDR_W'($urandom_range(0, 7));
            cycle("rand", last_g);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Shares the register file's single write port among NUM_REQ writeback requesters (ALU, load unit, mult/div) using round-robin arbitration.
- Tracks outstanding writes per architectural register with a pending-write scoreboard.
- Drives the register file's write_address, write_data_in and WriteEnable inputs.
- Gives decode busy/stall indications for its two source registers.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..4)
ADDR_W, 5, register address width (32 registers)
DATA_W, 32, register data width
CNT_W, 2, per-register outstanding-write counter width (max 2^CNT_W-1 pending)

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a write pending
req_addr  in  NUM_REQ*ADDR_W  destination register, slice i
req_data  in  NUM_REQ*DATA_W  write data, slice i
req_ready  out  NUM_REQ  grant; one-hot or zero, combinational
reserve_valid  in  1  decode reserves a destination register
reserve_addr  in  ADDR_W  register being reserved
reserve_ready  out  1  reservation accepted this cycle
check_addr_1  in  ADDR_W  decode source register 1
check_addr_2  in  ADDR_W  decode source register 2
busy_1  out  1  source 1 has an outstanding write
busy_2  out  1  source 2 has an outstanding write
stall  out  1  busy_1 OR busy_2
rf_write_address  out  ADDR_W  to register file write_address
rf_write_data  out  DATA_W  to register file write_data_in
rf_write_enable  out  1  to register file WriteEnable

Behaviour:
Reset:
- While reset=1 at posedge: rr_ptr=0, all counters=0, rf_write_enable=0, rf_write_address=0, rf_write_data=0.
- req_ready=0 and reserve_ready=0 while reset is high.
Arbitration:
- Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ; the first valid index gets req_ready=1. No valid requester means req_ready=0.
- A transfer occurs on a posedge where req_valid[i] & req_ready[i]. rr_ptr then becomes (i+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- At most one transfer per cycle. A requester must hold valid, addr and data stable until its transfer.
Write port:
- Latency is 1 cycle. rf_write_* are registered from the winner's addr/data at the transfer posedge.
- rf_write_enable=1 for exactly one cycle, and only if the transferred addr != 0.
- A transfer to address 0 is accepted and discarded: rf_write_enable=0, scoreboard unchanged.
- With no transfer, rf_write_enable=0 next cycle; rf_write_address and rf_write_data hold.
Scoreboard:
- Counter cnt[r] for r=1..31; cnt[0] is always 0.
- Reserve: when reserve_valid & reserve_ready at posedge and reserve_addr != 0, cnt[reserve_addr] increments.
- reserve_ready = (reserve_addr == 0) OR (cnt[reserve_addr] != max).
- Release: at any posedge where rf_write_enable=1, cnt[rf_write_address] decrements. The decrement coincides with the register file's write edge, so a source unblocked afterwards reads fresh data.
- Simultaneous reserve and release of the same register: counter unchanged.
- Release of a register whose count is 0 (unreserved write): counter stays 0; no underflow.
Hazard outputs:
- busy_k = (check_addr_k != 0) & (cnt[check_addr_k] != 0), combinational from current counters.
- stall = busy_1 | busy_2.
Reset mid-operation:
- Pending transfers and reservations are dropped.
- rf_write_enable deasserts the cycle after reset is sampled, even if a write had just been granted.

Optional Feature:
- Macro: REGFILE_WRITE_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index valid requester always wins. rr_ptr is not implemented and starvation is permitted.
- Undefined (default): round-robin as specified above.

Test Plan:
- Reset, then req_valid=3'b111 held with addrs 5/6/7, data A/B/C. Grants go 0,1,2,0 on successive cycles. rf_write_address=5,6,7 with enable high one cycle after each grant.
- Reserve r9 twice (cnt=2), check_addr_1=9: busy_1=1, stall=1. Two writes to r9 complete: busy_1 stays 1 after the first and clears at the posedge of the second rf_write_enable.
- Reserve r4 with cnt[4]=3: reserve_ready=0, cnt unchanged. Reserve r0 anytime: reserve_ready=1, no counter change, check_addr_1=0 gives busy_1=0.
- Requester 1 writes r0 with data 0xDEADBEEF: transfer occurs, rf_write_enable stays 0, rr_ptr advances to 2.
- In one cycle, reserve r12 while an rf write to r12 is in flight with cnt=1: cnt stays 1, busy reflects 1.
- Assert reset in the cycle of a transfer to r3: next cycle rf_write_enable=0, all busy=0, rr_ptr=0, the next grant goes to the lowest valid index.
